// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron layer: default width, leak-shift width
// and a width-bounded saturating adder.
package lif_pkg;
    localparam int LIF_WIDTH = 8;
    localparam int BETA_W    = 3;
    localparam int SAT_MAX_W = 31;

    // Unsigned a+b clamped to 2^w-1; callers keep w <= SAT_MAX_W.
    function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                     input logic [SAT_MAX_W-1:0] b,
                                                     input int w);
        logic [SAT_MAX_W:0] s;
        logic [SAT_MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        return (s > lim) ? lim[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
    endfunction
endpackage

// File: rtl/lif_if.sv
// Control/data bundle of the LIF layer: shared controls and currents in,
// spikes, busy flags and the selected membrane state out.
interface lif_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 2,
    parameter int WIDTH     = LIF_WIDTH,
    parameter int SEL_W     = 1
);
    logic                        en;
    logic [N_NEURONS*WIDTH-1:0]  current;
    logic [BETA_W-1:0]           beta_shift;
    logic [WIDTH-1:0]            threshold;
    logic [SEL_W-1:0]            state_sel;
    logic [N_NEURONS-1:0]        spike;
    logic [WIDTH-1:0]            state_out;
    logic [N_NEURONS-1:0]        refrac_busy;

    modport master (
        output en, current, beta_shift, threshold, state_sel,
        input  spike, state_out, refrac_busy
    );
    modport slave (
        input  en, current, beta_shift, threshold, state_sel,
        output spike, state_out, refrac_busy
    );
endinterface

// File: rtl/lif_cell.sv
// One leaky-integrate-and-fire neuron: membrane state, registered spike and
// refractory hold counter.
module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH         = LIF_WIDTH,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  current,
    input  logic [BETA_W-1:0] beta_shift,
    input  logic [WIDTH-1:0]  threshold,
    output logic [WIDTH-1:0]  state,
    output logic              spike,
    output logic              refrac_busy
);
    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRAC_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] sum;

    // state >> k never exceeds state, so the leak subtraction cannot underflow.
    always_comb begin
        leaked = state - (state >> beta_shift);
        sum    = WIDTH'(sat_add(SAT_MAX_W'(leaked), SAT_MAX_W'(current), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            spike <= 1'b0;
            cnt   <= '0;
        end else if (en) begin
            if (cnt != '0) begin
                cnt   <= cnt - CNT_W'(1);
                state <= '0;
                spike <= 1'b0;
            end else if (sum >= threshold) begin
                cnt   <= CNT_LOAD;
                state <= '0;
                spike <= 1'b1;
            end else begin
                state <= sum;
                spike <= 1'b0;
            end
        end
    end

    assign refrac_busy = (cnt != '0);
endmodule

// File: rtl/lif_layer.sv
// Layer of independent LIF neurons sharing leak/threshold controls; one
// neuron's membrane state is muxed out by state_sel.
module lif_layer
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 2,
    parameter int WIDTH         = LIF_WIDTH,
    parameter int REFRAC_CYCLES = 2,
    parameter int SEL_W         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic clk,
    input  logic rst_n,
    lif_if.slave bus
);
    logic [N_NEURONS-1:0][WIDTH-1:0] states;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_cell
        lif_cell #(
            .WIDTH         (WIDTH),
            .REFRAC_CYCLES (REFRAC_CYCLES)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (bus.en),
            .current     (bus.current[i*WIDTH +: WIDTH]),
            .beta_shift  (bus.beta_shift),
            .threshold   (bus.threshold),
            .state       (states[i]),
            .spike       (bus.spike[i]),
            .refrac_busy (bus.refrac_busy[i])
        );
    end

    always_comb begin
        bus.state_out = '0;
        if (int'(bus.state_sel) < N_NEURONS)
            bus.state_out = states[bus.state_sel];
    end
endmodule

// File: tb/tb_lif_layer.sv
// Self-checking bench for lif_layer: directed scenarios plus randomized
// traffic against an integer reference model of the neuron rules.
module tb_lif_layer;
    import lif_pkg::*;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int R  = 2;
    localparam int SW = 1;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_if #(.N_NEURONS(N), .WIDTH(W), .SEL_W(SW)) bus ();

    lif_layer #(
        .N_NEURONS     (N),
        .WIDTH         (W),
        .REFRAC_CYCLES (R),
        .SEL_W         (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int m_st[N];
    int m_sp[N];
    int m_cnt[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int c0, input int c1, input int bs, input int thr, input bit e);
        logic [W-1:0] a, b;
        a = W'(c0);
        b = W'(c1);
        bus.current    = {b, a};
        bus.beta_shift = BETA_W'(bs);
        bus.threshold  = W'(thr);
        bus.en         = e;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_sp[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Behavioural neuron: leak, add, clamp, then fire-or-integrate.
    task automatic model_step();
        int cur, thr, bs, nxt;
        if (bus.en !== 1'b1) return;
        thr = int'(bus.threshold);
        bs  = int'(bus.beta_shift);
        for (int i = 0; i < N; i++) begin
            cur = int'(bus.current[i*W +: W]);
            if (m_cnt[i] > 0) begin
                m_cnt[i]--; m_st[i] = 0; m_sp[i] = 0;
            end else begin
                nxt = m_st[i] - ((bs >= W) ? 0 : (m_st[i] / (1 << bs))) + cur;
                if (nxt > MAXV) nxt = MAXV;
                if (nxt >= thr) begin
                    m_sp[i] = 1; m_st[i] = 0; m_cnt[i] = R;
                end else begin
                    m_sp[i] = 0; m_st[i] = nxt;
                end
            end
        end
    endtask

    task automatic peek(input int i, output logic [31:0] v);
        bus.state_sel = SW'(i);
        #1;
        v = 32'(bus.state_out);
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] v;
        for (int i = 0; i < N; i++) begin
            peek(i, v);
            chk({tag, "_state"}, v, m_st[i]);
            chk({tag, "_spike"}, 32'(bus.spike[i]), m_sp[i]);
            chk({tag, "_busy"}, 32'(bus.refrac_busy[i]), (m_cnt[i] != 0) ? 1 : 0);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        logic [31:0] v;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_spike"}, 32'(bus.spike), 0);
        chk({tag, "_rst_busy"}, 32'(bus.refrac_busy), 0);
        peek(0, v);
        chk({tag, "_rst_state"}, v, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sc2[8] = '{40, 60, 70, 75, 78, 79, 80, 80};
        int sc3[8] = '{60, 90, 0, 0, 0, 60, 90, 0};
        int sp3[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
        bit en5[14] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        logic [31:0] v;

        model_clear();
        bus.state_sel = '0;
        set_in(0, 0, 0, 255, 1'b1);
        do_reset("init");

        // Leak fixed point at 80 below threshold.
        set_in(40, 0, 1, 100, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick("sc2");
            peek(0, v);
            chk("sc2_seq", v, sc2[k]);
            chk("sc2_nospike", 32'(bus.spike), 0);
        end

        // Crossing, refractory hold, then async reset while refractory.
        do_reset("pre3");
        set_in(60, 0, 1, 100, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick("sc3");
            peek(0, v);
            chk("sc3_seq", v, sc3[k]);
            chk("sc3_spike", 32'(bus.spike[0]), sp3[k]);
        end
        chk("sc3_busy_before_rst", 32'(bus.refrac_busy[0]), 1);
        do_reset("midrun");

        // Saturation instead of wrap.
        set_in(0, 200, 7, 255, 1'b1);
        tick("sc4");
        peek(1, v);
        chk("sc4_first", v, 200);
        tick("sc4");
        peek(1, v);
        chk("sc4_sat_state", v, 0);
        chk("sc4_spike", 32'(bus.spike), 2);

        // Freezing with en=0 during the crossing sequence.
        do_reset("pre5");
        for (int k = 0; k < 14; k++) begin
            set_in(60, 0, 1, 100, en5[k]);
            tick("sc5");
            if (k == 4) begin
                peek(0, v);
                chk("sc5_frozen_state", v, 90);
            end
            if (k == 9) chk("sc5_frozen_busy", 32'(bus.refrac_busy[0]), 1);
        end

        // Mux selection and simultaneous spikes.
        do_reset("pre6");
        set_in(30, 70, 0, 255, 1'b1);
        tick("sc6");
        peek(0, v);
        chk("sc6_sel0", v, 30);
        peek(1, v);
        chk("sc6_sel1", v, 70);
        set_in(60, 70, 0, 50, 1'b1);
        tick("sc6");
        chk("sc6_both_spike", 32'(bus.spike), 3);

        // Randomized traffic.
        do_reset("pre_rand");
        for (int k = 0; k < 400; k++) begin
            int thr;
            thr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(20, 255));
            set_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 7)), thr, ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
